uart_mem_arbiter: RTL and testbench
===================================

Name: uart_mem_arbiter

Overview:
- Shares one single-port byte RAM (UART mailbox/buffer region plus CPU data window) between three requesters: UART RX engine, UART TX engine and CPU data port.
- Sits between the UART interface's rx_/tx_ memory ports, the core's load/store byte port, and the RAM macro.
- Gives each requester a req/gnt handshake. A lock lets a UART engine own the RAM for its multi-cycle sequence. A starvation guard guarantees CPU progress.

Parameters:
- MABL, 11, RAM address width in bits.
- MAX_WAIT, 8, CPU wait cycles after which the CPU wins the next idle arbitration.
- LOCK_MAX, 16, maximum consecutive locked cycles before forced release.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_req, tx_req, cpu_req  in  1 each  access request for this cycle.
- rx_lock, tx_lock  in  1 each  hold ownership after the current granted cycle.
- rx_we, tx_we, cpu_we  in  1 each  write enable (1 = write, 0 = read).
- rx_ad, tx_ad, cpu_ad  in  MABL each  byte address.
- rx_wd, tx_wd, cpu_wd  in  8 each  write data.
- rx_gnt, tx_gnt, cpu_gnt  out  1 each  combinational grant; access is performed this cycle.
- rx_rvalid, tx_rvalid, cpu_rvalid  out  1 each  read data valid on rd (one cycle after a granted read).
- rd  out  8  read data, passed through from mem_rd to all requesters.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_ad  out  MABL  RAM address.
- mem_wd  out  8  RAM write data.
- mem_rd  in  8  RAM read data; synchronous RAM, 1-cycle latency.
- lock_err  out  1  sticky flag: a lock timeout occurred.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, owner=none, starve_cnt=0, lock_cnt=0.
  - All rvalid=0, lock_err=0.
  - All gnt and mem_en forced to 0 while rst_n is low.
  - A transfer in progress is abandoned; a pending rvalid is dropped.
- At most one gnt is high per cycle.
- mem_* are muxed combinationally from the granted port. mem_en = OR of grants.
- With no grant: mem_ad and mem_wd hold 0, mem_we=0.
- rX_rvalid is registered: it is 1 in cycle t+1 only if port X was granted a read (we=0) in cycle t. A granted write produces no rvalid.
- State IDLE arbitration, fixed priority rx > tx > cpu. Exception: if starve_cnt==MAX_WAIT and cpu_req=1, the CPU wins.
- IDLE -> OWN(p) when the winner p is rx or tx, is granted, and its lock=1 in that cycle. lock_cnt is set to 1.
- In OWN(p):
  - Only p can be granted, and only when req_p=1. A cycle with req_p=0 is an idle cycle and the lock is still held.
  - If lock_p=0 in a cycle, that cycle is still served (if req_p=1), then state -> IDLE.
  - lock_cnt increments each OWN cycle.
  - If lock_cnt reaches LOCK_MAX with lock_p still 1: state -> IDLE and lock_err <= 1 (sticky until reset). The cycle that reaches LOCK_MAX is still served.
- cpu_lock does not exist; the CPU is never locked.
- starve_cnt: +1 each cycle with cpu_req=1 and cpu_gnt=0, saturating at MAX_WAIT. Cleared to 0 on cpu_gnt.
- A locked owner is never preempted by starvation; the CPU waits for the release.
- Simultaneous release and request:
  - When the owner drops its lock in cycle t, arbitration resumes in cycle t+1.
  - No dead cycle is inserted beyond that.
  - The releasing port may win again at t+1 by priority, unless the CPU is starved.
- Requesters hold req/we/ad/wd stable until gnt. The arbiter does not latch request fields.

Decomposition:
- Shared package holds:
  - Port ID encoding: ID_NONE=0, ID_RX=1, ID_TX=2, ID_CPU=3 (2 bits).
  - State encoding: ST_IDLE, ST_OWN.
  - The MABL default, shared with the UART interface and core.
- One sub-module is natural: arb_prio3, a combinational priority picker with a force-CPU input.
- Counters, state and rvalid registers stay in the top module.

Test Plan:
- Reset mid-lock:
  - Stimulus: rx locked, read granted at ad=0x002; pull rst_n low before the next edge.
  - Response: all gnt=0 immediately; rx_rvalid stays 0; after release, state IDLE.
- Priority and latency:
  - Stimulus: rx_req, tx_req and cpu_req all high, all reads, RAM preloaded 0x001=0x5A.
  - Response: rx_gnt first; rx_rvalid next cycle with rd=0x5A; then tx, then cpu, one per cycle.
- Lock sequence:
  - Stimulus: rx does 5 locked accesses (read 0x001, read 0x002, write 0x002, write 0x001, then write 0x000=0x01 with lock=0) while tx_req and cpu_req are held high.
  - Response: only rx_gnt for 5 cycles, then tx_gnt.
- Starvation:
  - Stimulus: rx and tx issue alternating unlocked requests continuously; cpu_req held high.
  - Response: cpu_gnt asserted no later than cycle MAX_WAIT+1 = 9 after cpu_req rises; starve_cnt returns to 0.
- Lock timeout:
  - Stimulus: tx holds tx_lock=1 and tx_req=1 for 20 cycles.
  - Response: exactly 16 tx grants, then lock_err=1; a pending cpu_req is granted in cycle 17 (lock_cnt reaches LOCK_MAX in cycle 16).
- Write path:
  - Stimulus: cpu write ad=0x7FF, wd=0xA5, then cpu read 0x7FF.
  - Response: mem_we=1 with mem_ad=0x7FF in the write cycle; no cpu_rvalid for the write; read returns rd=0xA5 with cpu_rvalid one cycle after grant.

Source files
------------

// File: rtl/uart_mem_arbiter_pkg.sv
// Shared types and constants for the UART/CPU byte-RAM arbiter.
package uart_mem_arbiter_pkg;

  // Default RAM address width, shared with the UART interface and core.
  localparam int unsigned MABL_DEF = 11;

  // Requester identifiers.
  typedef logic [1:0] port_id_t;
  localparam port_id_t ID_NONE = 2'd0;
  localparam port_id_t ID_RX   = 2'd1;
  localparam port_id_t ID_TX   = 2'd2;
  localparam port_id_t ID_CPU  = 2'd3;

  // Arbiter state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // Only the UART engines may take a lock.
  function automatic logic is_uart(port_id_t id);
    return (id == ID_RX) || (id == ID_TX);
  endfunction

endpackage

// File: rtl/uart_mem_arbiter_if.sv
// Request/grant bus for the three RAM requesters plus the RAM macro port.
interface uart_mem_arbiter_if #(
  parameter int unsigned MABL = uart_mem_arbiter_pkg::MABL_DEF
);

  logic            rx_req, tx_req, cpu_req;
  logic            rx_lock, tx_lock;
  logic            rx_we, tx_we, cpu_we;
  logic [MABL-1:0] rx_ad, tx_ad, cpu_ad;
  logic [7:0]      rx_wd, tx_wd, cpu_wd;
  logic            rx_gnt, tx_gnt, cpu_gnt;
  logic            rx_rvalid, tx_rvalid, cpu_rvalid;
  logic [7:0]      rd;
  logic            mem_en, mem_we;
  logic [MABL-1:0] mem_ad;
  logic [7:0]      mem_wd;
  logic [7:0]      mem_rd;
  logic            lock_err;

  // Arbiter side.
  modport slave (
    input  rx_req, tx_req, cpu_req, rx_lock, tx_lock,
    input  rx_we, tx_we, cpu_we, rx_ad, tx_ad, cpu_ad, rx_wd, tx_wd, cpu_wd,
    output rx_gnt, tx_gnt, cpu_gnt, rx_rvalid, tx_rvalid, cpu_rvalid, rd,
    output mem_en, mem_we, mem_ad, mem_wd,
    input  mem_rd,
    output lock_err
  );

  // Requester and RAM side.
  modport master (
    output rx_req, tx_req, cpu_req, rx_lock, tx_lock,
    output rx_we, tx_we, cpu_we, rx_ad, tx_ad, cpu_ad, rx_wd, tx_wd, cpu_wd,
    input  rx_gnt, tx_gnt, cpu_gnt, rx_rvalid, tx_rvalid, cpu_rvalid, rd,
    input  mem_en, mem_we, mem_ad, mem_wd,
    output mem_rd,
    input  lock_err
  );

endinterface

// File: rtl/uart_mem_arbiter_arb_prio3.sv
// Fixed-priority picker rx > tx > cpu, with an override that hands the slot to the CPU.
module arb_prio3
  import uart_mem_arbiter_pkg::*;
(
  input  logic     rx_req,
  input  logic     tx_req,
  input  logic     cpu_req,
  input  logic     force_cpu,
  output port_id_t win
);

  // Pick the winner among the current requests.
  always_comb begin
    win = ID_NONE;
    if (force_cpu && cpu_req) begin
      win = ID_CPU;
    end else if (rx_req) begin
      win = ID_RX;
    end else if (tx_req) begin
      win = ID_TX;
    end else if (cpu_req) begin
      win = ID_CPU;
    end
  end

endmodule

// File: rtl/uart_mem_arbiter.sv
// Single-port byte-RAM arbiter for UART RX, UART TX and CPU with lock and starvation guard.
module uart_mem_arbiter
  import uart_mem_arbiter_pkg::*;
#(
  parameter int unsigned MABL     = MABL_DEF,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned LOCK_MAX = 16
) (
  input logic             clk,
  input logic             rst_n,
  uart_mem_arbiter_if.slave bus
);

  localparam int unsigned SW = $clog2(MAX_WAIT + 1);
  localparam int unsigned LW = $clog2(LOCK_MAX + 1);

  state_t          state_q, state_d;
  port_id_t        owner_q, owner_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [LW-1:0]   lock_cnt_inc;
  logic            lock_err_q, lock_err_d;
  logic            rx_rvalid_q, tx_rvalid_q, cpu_rvalid_q;

  port_id_t        pick_id, win_id, gnt_id;
  logic            force_cpu;
  logic            owner_req, owner_lock;
  logic            rx_gnt, tx_gnt, cpu_gnt;
  logic            mem_we;
  logic [MABL-1:0] mem_ad;
  logic [7:0]      mem_wd;

  assign force_cpu = bus.cpu_req && (starve_q == SW'(MAX_WAIT));

  arb_prio3 u_arb_prio3 (
    .rx_req    (bus.rx_req),
    .tx_req    (bus.tx_req),
    .cpu_req   (bus.cpu_req),
    .force_cpu (force_cpu),
    .win       (pick_id)
  );

  // Request and lock of the current lock owner.
  always_comb begin
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    if (owner_q == ID_RX) begin
      owner_req  = bus.rx_req;
      owner_lock = bus.rx_lock;
    end else if (owner_q == ID_TX) begin
      owner_req  = bus.tx_req;
      owner_lock = bus.tx_lock;
    end
  end

  // Grant selection; reset blanks every grant immediately.
  always_comb begin
    win_id = ID_NONE;
    if (state_q == ST_IDLE) begin
      win_id = pick_id;
    end else if (owner_req) begin
      win_id = owner_q;
    end
    gnt_id  = rst_n ? win_id : ID_NONE;
    rx_gnt  = (gnt_id == ID_RX);
    tx_gnt  = (gnt_id == ID_TX);
    cpu_gnt = (gnt_id == ID_CPU);
  end

  // RAM port mux from the granted requester; idle bus drives zeros.
  always_comb begin
    mem_we = 1'b0;
    mem_ad = '0;
    mem_wd = '0;
    case (gnt_id)
      ID_RX: begin
        mem_we = bus.rx_we;
        mem_ad = bus.rx_ad;
        mem_wd = bus.rx_wd;
      end
      ID_TX: begin
        mem_we = bus.tx_we;
        mem_ad = bus.tx_ad;
        mem_wd = bus.tx_wd;
      end
      ID_CPU: begin
        mem_we = bus.cpu_we;
        mem_ad = bus.cpu_ad;
        mem_wd = bus.cpu_wd;
      end
      default: ;
    endcase
  end

  assign bus.rx_gnt     = rx_gnt;
  assign bus.tx_gnt     = tx_gnt;
  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.mem_en     = rx_gnt | tx_gnt | cpu_gnt;
  assign bus.mem_we     = mem_we;
  assign bus.mem_ad     = mem_ad;
  assign bus.mem_wd     = mem_wd;
  assign bus.rd         = bus.mem_rd;
  assign bus.rx_rvalid  = rx_rvalid_q;
  assign bus.tx_rvalid  = tx_rvalid_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.lock_err   = lock_err_q;

  assign lock_cnt_inc = lock_cnt_q + LW'(1);

  // Lock FSM next state: enter on a locked UART grant, leave on release or timeout.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    lock_err_d = lock_err_q;
    case (state_q)
      ST_IDLE: begin
        if (is_uart(gnt_id) &&
            (((gnt_id == ID_RX) && bus.rx_lock) || ((gnt_id == ID_TX) && bus.tx_lock))) begin
          state_d    = ST_OWN;
          owner_d    = gnt_id;
          lock_cnt_d = LW'(1);
        end
      end
      ST_OWN: begin
        lock_cnt_d = lock_cnt_inc;
        if (!owner_lock) begin
          state_d    = ST_IDLE;
          owner_d    = ID_NONE;
          lock_cnt_d = '0;
        end else if (lock_cnt_inc >= LW'(LOCK_MAX)) begin
          // Held too long: this cycle is still served, then force release.
          state_d    = ST_IDLE;
          owner_d    = ID_NONE;
          lock_cnt_d = '0;
          lock_err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = ID_NONE;
      end
    endcase
  end

  // CPU wait counter: count ungranted request cycles, saturate, clear on grant.
  always_comb begin
    starve_d = starve_q;
    if (cpu_gnt) begin
      starve_d = '0;
    end else if (bus.cpu_req && (starve_q != SW'(MAX_WAIT))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // State, counters and read-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= ID_NONE;
      starve_q     <= '0;
      lock_cnt_q   <= '0;
      lock_err_q   <= 1'b0;
      rx_rvalid_q  <= 1'b0;
      tx_rvalid_q  <= 1'b0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_q     <= starve_d;
      lock_cnt_q   <= lock_cnt_d;
      lock_err_q   <= lock_err_d;
      rx_rvalid_q  <= rx_gnt & ~bus.rx_we;
      tx_rvalid_q  <= tx_gnt & ~bus.tx_we;
      cpu_rvalid_q <= cpu_gnt & ~bus.cpu_we;
    end
  end

endmodule

// File: tb/tb_uart_mem_arbiter.sv
// Directed self-checking bench for uart_mem_arbiter with a 1-cycle-latency RAM model.
module tb_uart_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uart_mem_arbiter_if #(.MABL(11)) bus ();

  uart_mem_arbiter #(
    .MABL     (11),
    .MAX_WAIT (8),
    .LOCK_MAX (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous RAM model with a bench-side preload port.
  logic [7:0]  ram [2048];
  logic [7:0]  mem_rd_q = 8'h00;
  logic        pre_we = 1'b0;
  logic [10:0] pre_ad = '0;
  logic [7:0]  pre_wd = '0;

  always @(posedge clk) begin
    if (pre_we) begin
      ram[pre_ad] <= pre_wd;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_ad] <= bus.mem_wd;
      else            mem_rd_q <= ram[bus.mem_ad];
    end
  end

  assign bus.mem_rd = mem_rd_q;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [10:0] ad, input logic [7:0] wd);
    pre_ad = ad;
    pre_wd = wd;
    pre_we = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // id: 1=rx, 2=tx, 3=cpu
  task automatic drv(input int id, input logic req, input logic lock, input logic we,
                     input logic [10:0] ad, input logic [7:0] wd);
    case (id)
      1: begin
        bus.rx_req = req; bus.rx_lock = lock; bus.rx_we = we; bus.rx_ad = ad; bus.rx_wd = wd;
      end
      2: begin
        bus.tx_req = req; bus.tx_lock = lock; bus.tx_we = we; bus.tx_ad = ad; bus.tx_wd = wd;
      end
      default: begin
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_ad = ad; bus.cpu_wd = wd;
      end
    endcase
  endtask

  function automatic logic [2:0] gnts();
    return {bus.rx_gnt, bus.tx_gnt, bus.cpu_gnt};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_cpu, second_cpu, ntx, cpu_at;
    logic err16, err17;

    rst_n = 1'b0;
    drv(1, 0, 0, 0, 11'h0, 8'h0);
    drv(2, 0, 0, 0, 11'h0, 8'h0);
    drv(3, 0, 0, 0, 11'h0, 8'h0);
    preload(11'h001, 8'h5A);
    preload(11'h002, 8'h11);
    preload(11'h003, 8'h22);

    // Reset state with requests present
    @(negedge clk);
    drv(1, 1, 1, 0, 11'h001, 8'h0);
    drv(3, 1, 0, 0, 11'h003, 8'h0);
    #1;
    check_val("rst_gnt", gnts(), 3'b000);
    check_val("rst_mem_en", bus.mem_en, 1'b0);
    check_val("rst_rvalid", {bus.rx_rvalid, bus.tx_rvalid, bus.cpu_rvalid}, 3'b000);
    check_val("rst_lock_err", bus.lock_err, 1'b0);
    drv(1, 0, 0, 0, 11'h0, 8'h0);
    drv(3, 0, 0, 0, 11'h0, 8'h0);

    // Priority and read latency
    @(negedge clk);
    rst_n = 1'b1;
    drv(1, 1, 0, 0, 11'h001, 8'h0);
    drv(2, 1, 0, 0, 11'h002, 8'h0);
    drv(3, 1, 0, 0, 11'h003, 8'h0);
    #1;
    check_val("prio_c1_gnt", gnts(), 3'b100);
    check_val("prio_c1_ad", bus.mem_ad, 11'h001);
    @(negedge clk);
    bus.rx_req = 1'b0;
    #1;
    check_val("prio_c2_gnt", gnts(), 3'b010);
    check_val("prio_c2_rx_rvalid", bus.rx_rvalid, 1'b1);
    check_val("prio_c2_rd", bus.rd, 8'h5A);
    @(negedge clk);
    bus.tx_req = 1'b0;
    #1;
    check_val("prio_c3_gnt", gnts(), 3'b001);
    check_val("prio_c3_tx_rd", bus.rd, 8'h11);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    check_val("prio_c4_cpu_rvalid", bus.cpu_rvalid, 1'b1);
    check_val("prio_c4_rd", bus.rd, 8'h22);
    check_val("prio_c4_idle_bus", {bus.mem_en, bus.mem_we, bus.mem_ad, bus.mem_wd}, 32'h0);

    // Locked rx sequence with tx and cpu waiting
    @(negedge clk);
    drv(1, 1, 1, 0, 11'h001, 8'h00);
    drv(2, 1, 0, 0, 11'h002, 8'h00);
    drv(3, 1, 0, 0, 11'h000, 8'h00);
    #1 check_val("lock_c1_gnt", gnts(), 3'b100);
    @(negedge clk);
    drv(1, 1, 1, 0, 11'h002, 8'h00);
    #1 check_val("lock_c2_gnt", gnts(), 3'b100);
    check_val("lock_c2_rd", bus.rd, 8'h5A);
    @(negedge clk);
    drv(1, 1, 1, 1, 11'h002, 8'h33);
    #1 check_val("lock_c3_gnt", gnts(), 3'b100);
    check_val("lock_c3_we", bus.mem_we, 1'b1);
    @(negedge clk);
    drv(1, 1, 1, 1, 11'h001, 8'h44);
    #1 check_val("lock_c4_gnt", gnts(), 3'b100);
    @(negedge clk);
    drv(1, 1, 0, 1, 11'h000, 8'h01);
    #1 check_val("lock_c5_gnt", gnts(), 3'b100);
    check_val("lock_c5_ad", bus.mem_ad, 11'h000);
    @(negedge clk);
    drv(1, 0, 0, 0, 11'h000, 8'h00);
    #1 check_val("lock_c6_gnt", gnts(), 3'b010);
    @(negedge clk);
    bus.tx_req = 1'b0;
    #1 check_val("lock_c7_gnt", gnts(), 3'b001);
    check_val("lock_c7_tx_rd", bus.rd, 8'h33);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1 check_val("lock_c8_cpu_rd", bus.rd, 8'h01);

    // CPU write then read at the top address
    @(negedge clk);
    drv(3, 1, 0, 1, 11'h7FF, 8'hA5);
    #1 check_val("wr_gnt", gnts(), 3'b001);
    check_val("wr_bus", {bus.mem_we, bus.mem_ad, bus.mem_wd}, {1'b1, 11'h7FF, 8'hA5});
    @(negedge clk);
    drv(3, 1, 0, 0, 11'h7FF, 8'h00);
    #1 check_val("wr_no_rvalid", bus.cpu_rvalid, 1'b0);
    check_val("rd_we", bus.mem_we, 1'b0);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1 check_val("rd_rvalid", bus.cpu_rvalid, 1'b1);
    check_val("rd_data", bus.rd, 8'hA5);

    // Starvation: alternating unlocked rx/tx, cpu held high
    first_cpu  = 0;
    second_cpu = 0;
    drv(1, 0, 0, 0, 11'h004, 8'h00);
    drv(2, 0, 0, 0, 11'h005, 8'h00);
    drv(3, 1, 0, 0, 11'h006, 8'h00);
    for (int i = 1; i <= 30 && second_cpu == 0; i++) begin
      @(negedge clk);
      bus.rx_req = i[0];
      bus.tx_req = ~i[0];
      #1;
      if (bus.cpu_gnt) begin
        if (first_cpu == 0) first_cpu = i;
        else                second_cpu = i;
      end
    end
    check_val("starve_first", first_cpu, 9);
    check_val("starve_second", second_cpu, 18);
    @(negedge clk);
    drv(1, 0, 0, 0, 11'h0, 8'h0);
    drv(2, 0, 0, 0, 11'h0, 8'h0);
    drv(3, 0, 0, 0, 11'h0, 8'h0);

    // Lock timeout: tx holds the lock for 20 cycles, cpu pending
    ntx    = 0;
    cpu_at = 0;
    err16  = 1'bx;
    err17  = 1'bx;
    @(negedge clk);
    drv(2, 1, 1, 0, 11'h003, 8'h00);
    drv(3, 1, 0, 0, 11'h001, 8'h00);
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      #1;
      if (i <= 17 && bus.tx_gnt) ntx++;
      if (bus.cpu_gnt && cpu_at == 0) cpu_at = i;
      if (i == 16) err16 = bus.lock_err;
      if (i == 17) err17 = bus.lock_err;
    end
    check_val("tmo_tx_grants", ntx, 16);
    check_val("tmo_cpu_cycle", cpu_at, 17);
    check_val("tmo_err_c16", err16, 1'b0);
    check_val("tmo_err_c17", err17, 1'b1);
    @(negedge clk);
    drv(2, 0, 0, 0, 11'h0, 8'h0);
    drv(3, 0, 0, 0, 11'h0, 8'h0);
    @(negedge clk);
    #1 check_val("tmo_err_sticky", bus.lock_err, 1'b1);

    // Reset in the middle of a locked read
    @(negedge clk);
    drv(1, 1, 1, 0, 11'h002, 8'h00);
    #1 check_val("mrst_gnt_before", gnts(), 3'b100);
    #1 rst_n = 1'b0;
    #1 check_val("mrst_gnt_during", gnts(), 3'b000);
    check_val("mrst_mem_en", bus.mem_en, 1'b0);
    @(negedge clk);
    check_val("mrst_rvalid", bus.rx_rvalid, 1'b0);
    check_val("mrst_lock_err", bus.lock_err, 1'b0);
    rst_n = 1'b1;
    drv(1, 0, 0, 0, 11'h000, 8'h00);
    drv(2, 1, 0, 0, 11'h001, 8'h00);
    #1 check_val("mrst_idle_tx_gnt", gnts(), 3'b010);
    @(negedge clk);
    bus.tx_req = 1'b0;
    #1 check_val("mrst_tx_rd", {bus.tx_rvalid, bus.rd}, {1'b1, 8'h44});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
